// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback decoder.
// Holds the 16 legal hex segment patterns (seg[6]=a .. seg[0]=g, active-low),
// the all-off blank pattern and the capture FSM state type.
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Indexed by hex value.
   localparam logic [6:0] SEG_TABLE [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

   typedef enum logic {
      StWait,
      StCapture
   } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern decoder.
// Ports:
//   i_pattern  - 7-bit active-low segment pattern (a..g on bits 6..0)
//   o_nibble   - hex value of a legal pattern, 0 otherwise
//   o_is_legal - pattern is one of the 16 hex glyphs
//   o_is_blank - pattern is all segments off
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic [3:0] o_nibble,
   output logic       o_is_legal,
   output logic       o_is_blank
);

   always_comb begin
      o_nibble   = 4'h0;
      o_is_legal = 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
         if (i_pattern == SEG_TABLE[k]) begin
            o_nibble   = 4'(k);
            o_is_legal = 1'b1;
         end
      end
      o_is_blank = (i_pattern == SEG_BLANK);
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed, active-low 7-segment display.
// Waits for each {an, seg} sample to be stable, decodes the selected digit's
// pattern and assembles a DIGITS-wide word with per-frame error flagging.
// Ports:
//   i_clk, i_rst    - clock and synchronous active-high reset
//   i_an            - active-low digit enables (exactly one low selects a digit)
//   i_seg           - active-low segments, [6]=a .. [0]=g
//   o_value         - decoded nibbles, digit i at [4i+3:4i]
//   o_digit_valid   - last capture of digit i was a legal glyph
//   o_blank         - last capture of digit i was all-off
//   o_err           - one-cycle pulse per illegal capture
//   o_frame_valid   - one-cycle pulse when every digit has been captured
//   o_frame_err     - with o_frame_valid: the frame held an illegal capture
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DIGITS-1:0]     i_an,
   input  logic [6:0]            i_seg,
   output logic [4*DIGITS-1:0]   o_value,
   output logic [DIGITS-1:0]     o_digit_valid,
   output logic [DIGITS-1:0]     o_blank,
   output logic                  o_err,
   output logic                  o_frame_valid,
   output logic                  o_frame_err
);

   localparam int unsigned SW = DIGITS + 7;
   localparam int unsigned CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [SW-1:0]       r_sample;
   logic [CW-1:0]       r_cnt;
   state_t              r_state;
   logic [DIGITS-1:0]   r_mask;
   logic                r_ferr_acc;
   logic [4*DIGITS-1:0] r_value;
   logic [DIGITS-1:0]   r_digit_valid;
   logic [DIGITS-1:0]   r_blank;
   logic                r_err;
   logic                r_frame_valid;
   logic                r_frame_err;

   logic [SW-1:0]       w_sample;
   logic                w_same;
   logic [CW-1:0]       w_cnt_next;
   logic [DIGITS-1:0]   w_an_low;
   logic                w_onehot;
   state_t              w_state_next;
   logic                w_capture;
   logic [3:0]          w_nibble;
   logic                w_legal;
   logic                w_is_blank;
   logic                w_illegal;
   logic [DIGITS-1:0]   w_mask_next;
   logic                w_ferr_next;

   seg7_pattern_decode u_decode (
      .i_pattern  (i_seg),
      .o_nibble   (w_nibble),
      .o_is_legal (w_legal),
      .o_is_blank (w_is_blank)
   );

   assign w_sample   = {i_an, i_seg};
   assign w_same     = (w_sample == r_sample);
   assign w_cnt_next = !w_same ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

   // Selected digit as a one-hot mask; reused directly as the write enable.
   assign w_an_low = ~i_an;
   assign w_onehot = (w_an_low != '0) && ((w_an_low & (w_an_low - 1'b1)) == '0);

   assign w_illegal   = !w_legal && !w_is_blank;
   assign w_mask_next = r_mask | w_an_low;
   assign w_ferr_next = r_ferr_acc | w_illegal;

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      unique case (r_state)
         StWait: begin
            if (w_same && (r_cnt == CNT_MAX) && w_onehot) begin
               w_capture    = 1'b1;
               w_state_next = StCapture;
            end
         end
         StCapture: begin
            // Holding here blocks re-capture until the sample changes.
            if (!w_same) w_state_next = StWait;
         end
         default: w_state_next = StWait;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sample      <= '1;
         r_cnt         <= '0;
         r_state       <= StWait;
         r_mask        <= '0;
         r_ferr_acc    <= 1'b0;
         r_value       <= '0;
         r_digit_valid <= '0;
         r_blank       <= '0;
         r_err         <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_sample      <= w_sample;
         r_cnt         <= w_cnt_next;
         r_state       <= w_state_next;
         r_err         <= 1'b0;
         r_frame_valid <= 1'b0;
         if (w_capture) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (w_an_low[i]) begin
                  if (w_legal) r_value[4*i +: 4] <= w_nibble;
                  r_digit_valid[i] <= w_legal;
                  r_blank[i]       <= w_is_blank;
               end
            end
            r_err <= w_illegal;
            if (w_mask_next == '1) begin
               r_frame_valid <= 1'b1;
               r_frame_err   <= w_ferr_next;
               r_mask        <= '0;
               r_ferr_acc    <= 1'b0;
            end else begin
               r_mask     <= w_mask_next;
               r_ferr_acc <= w_ferr_next;
            end
         end
      end
   end

   assign o_value       = r_value;
   assign o_digit_valid = r_digit_valid;
   assign o_blank       = r_blank;
   assign o_err         = r_err;
   assign o_frame_valid = r_frame_valid;
   assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4): directed vectors,
// a run-length based reference model and per-cycle output comparison.
module tb_seg7_scan_decoder;

   localparam int ST = 4;

   // Glyph table written out independently of the design package.
   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an  = 4'b1111;
   logic [6:0]  seg = 7'b1111111;
   logic [15:0] value;
   logic [3:0]  digit_valid;
   logic [3:0]  blank;
   logic        err;
   logic        frame_valid;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   seg7_scan_decoder #(
      .DIGITS        (4),
      .STABLE_CYCLES (ST)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_an          (an),
      .i_seg         (seg),
      .o_value       (value),
      .o_digit_valid (digit_valid),
      .o_blank       (blank),
      .o_err         (err),
      .o_frame_valid (frame_valid),
      .o_frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a capture happens when the sample has repeated exactly
   // ST times in a row and exactly one digit enable is low.
   logic [10:0] m_prev;
   int          m_run;
   logic [15:0] m_value;
   logic [3:0]  m_dv, m_blank, m_seen;
   logic        m_err, m_fv, m_ferr, m_acc;
   bit          m_ready = 1'b0;
   int          m_d, m_zeros, m_nib;
   bit          m_legal, m_isblank;

   always @(posedge clk) begin
      if (rst) begin
         m_prev = '1; m_run = 0; m_value = '0; m_dv = '0; m_blank = '0;
         m_seen = '0; m_err = 0; m_fv = 0; m_ferr = 0; m_acc = 0;
         m_ready = 1'b1;
      end else if (m_ready) begin
         m_err = 0;
         m_fv  = 0;
         if ({an, seg} == m_prev) m_run++;
         else m_run = 0;
         m_prev  = {an, seg};
         m_zeros = 0;
         for (int i = 0; i < 4; i++) if (!an[i]) begin m_zeros++; m_d = i; end
         if (m_run == ST && m_zeros == 1) begin
            m_legal = 0; m_nib = 0;
            for (int k = 0; k < 16; k++) if (seg == GLYPH[k]) begin m_legal = 1; m_nib = k; end
            m_isblank = (seg == 7'b1111111);
            if (m_legal) m_value[4*m_d +: 4] = 4'(m_nib);
            m_dv[m_d]    = m_legal;
            m_blank[m_d] = m_isblank;
            if (!m_legal && !m_isblank) begin m_err = 1; m_acc = 1; end
            m_seen[m_d] = 1'b1;
            if (m_seen == 4'b1111) begin
               m_fv = 1; m_ferr = m_acc; m_seen = '0; m_acc = 0;
            end
         end
      end
   end

   // Per-cycle compare plus pulse bookkeeping for the directed checks.
   int  n_fv = 0, n_err = 0;
   logic last_ferr = 1'b0;

   always @(negedge clk) begin
      if (m_ready) begin
         chk("value", 32'(value), 32'(m_value));
         chk("digit_valid", 32'(digit_valid), 32'(m_dv));
         chk("blank", 32'(blank), 32'(m_blank));
         chk("err", 32'(err), 32'(m_err));
         chk("frame_valid", 32'(frame_valid), 32'(m_fv));
         if (m_fv) chk("frame_err", 32'(frame_err), 32'(m_ferr));
         if (frame_valid) begin n_fv++; last_ferr = frame_err; end
         if (err) n_err++;
      end
   end

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_flags", 32'({digit_valid, blank, err, frame_valid, frame_err}), 32'h0);

      // Single digit: capture on the 5th sampling edge.
      drive(4'b1110, GLYPH[3], 4);
      chk("dwell4_value", 32'(value), 32'h0);
      drive(4'b1110, GLYPH[3], 1);
      chk("dwell5_value", 32'(value[3:0]), 32'h3);
      chk("dwell5_dv", 32'(digit_valid), 32'h1);

      // Full frame A5C9.
      do_reset();
      n_fv = 0; n_err = 0;
      drive(4'b0111, GLYPH[10], 6);
      drive(4'b1011, GLYPH[5], 6);
      drive(4'b1101, GLYPH[12], 6);
      drive(4'b1110, GLYPH[9], 6);
      chk("frame_value", 32'(value), 32'hA5C9);
      chk("frame_model_value", 32'(m_value), 32'hA5C9);
      chk("frame_dv", 32'(digit_valid), 32'hF);
      chk("frame_pulses", 32'(n_fv), 32'd1);
      chk("frame_err_clean", 32'(last_ferr), 32'd0);

      // Illegal pattern on digit 2, blank on digit 1, frame flagged.
      n_fv = 0; n_err = 0;
      drive(4'b1011, 7'b1010101, 6);
      chk("illegal_err_pulses", 32'(n_err), 32'd1);
      chk("illegal_dv2", 32'(digit_valid[2]), 32'd0);
      chk("illegal_nibble_held", 32'(value[11:8]), 32'h5);
      drive(4'b0111, GLYPH[10], 6);
      drive(4'b1101, 7'b1111111, 6);
      drive(4'b1110, GLYPH[9], 6);
      chk("illegal_frame_pulses", 32'(n_fv), 32'd1);
      chk("illegal_frame_err", 32'(last_ferr), 32'd1);
      chk("blank_mask", 32'(blank), 32'h2);
      chk("blank_dv", 32'(digit_valid), 32'h9);
      chk("blank_value_held", 32'(value), 32'hA5C9);

      // Short glitch of 8 between stable 1s on digit 0.
      drive(4'b1110, GLYPH[1], 6);
      drive(4'b1110, GLYPH[8], 3);
      chk("glitch_value", 32'(value[3:0]), 32'h1);
      drive(4'b1110, GLYPH[1], 6);
      chk("glitch_after", 32'(value[3:0]), 32'h1);

      // Invalid digit selects are ignored.
      n_fv = 0; n_err = 0;
      drive(4'b1100, GLYPH[8], 20);
      drive(4'b1111, GLYPH[8], 20);
      chk("noselect_value", 32'(value), 32'hA5C1);
      chk("noselect_pulses", 32'(n_fv + n_err), 32'd0);

      // Reset in the middle of a dwell.
      drive(4'b1110, GLYPH[7], 2);
      do_reset();
      chk("midrst_value", 32'(value), 32'h0);
      chk("midrst_dv", 32'(digit_valid), 32'h0);
      drive(4'b1110, GLYPH[7], 4);
      chk("midrst_early", 32'(value), 32'h0);
      drive(4'b1110, GLYPH[7], 1);
      chk("midrst_capture", 32'(value[3:0]), 32'h7);
      chk("midrst_model", 32'(m_value), 32'h7);

      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
